// File: rtl/rvfi_trace_buffer.sv
// RVFI retirement-trace FIFO: queues retirement packets for a trace sink,
// checks order/PC continuity and counts packets dropped on overflow.
module rvfi_trace_buffer #(
    parameter int  DEPTH = 8,
    localparam int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic            clock,
    input  logic            reset,

    input  logic            in_valid,
    input  logic [63:0]     in_order,
    input  logic [31:0]     in_insn,
    input  logic            in_trap,
    input  logic [31:0]     in_pc_rdata,
    input  logic [31:0]     in_pc_wdata,
    input  logic [4:0]      in_rd_addr,
    input  logic [31:0]     in_rd_wdata,
    input  logic [31:0]     in_mem_addr,
    input  logic [3:0]      in_mem_wmask,
    input  logic [31:0]     in_mem_wdata,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [63:0]     out_order,
    output logic [31:0]     out_insn,
    output logic            out_trap,
    output logic [31:0]     out_pc_rdata,
    output logic [31:0]     out_pc_wdata,
    output logic [4:0]      out_rd_addr,
    output logic [31:0]     out_rd_wdata,
    output logic [31:0]     out_mem_addr,
    output logic [3:0]      out_mem_wmask,
    output logic [31:0]     out_mem_wdata,

    output logic [CNTW-1:0] count,
    output logic            overflow,
    output logic [15:0]     drop_count,
    output logic            order_err,
    output logic            pc_err
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] insn;
        logic        trap;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_wdata;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          in_entry;
    entry_t          head;

    logic [AW-1:0]   wp_q, wp_d;
    logic [AW-1:0]   rp_q, rp_d;
    logic [CNTW-1:0] count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     drop_count_q, drop_count_d;
    logic            order_err_q, order_err_d;
    logic            pc_err_q, pc_err_d;
    logic [63:0]     exp_order_q, exp_order_d;
    logic            have_prev_q, have_prev_d;
    logic [31:0]     prev_pc_wdata_q, prev_pc_wdata_d;
    logic            prev_trap_q, prev_trap_d;

    logic            push;
    logic            pop;
    logic            drop;

    assign in_entry = '{
        order:     in_order,
        insn:      in_insn,
        trap:      in_trap,
        pc_rdata:  in_pc_rdata,
        pc_wdata:  in_pc_wdata,
        rd_addr:   in_rd_addr,
        rd_wdata:  in_rd_wdata,
        mem_addr:  in_mem_addr,
        mem_wmask: in_mem_wmask,
        mem_wdata: in_mem_wdata
    };

    // A full FIFO still accepts a packet when the head leaves in the same cycle.
    assign pop  = out_valid && out_ready;
    assign push = in_valid && ((count_q < CNTW'(DEPTH)) || pop);
    assign drop = in_valid && !push;

    always_comb begin
        wp_d            = wp_q;
        rp_d            = rp_q;
        count_d         = count_q;
        overflow_d      = overflow_q;
        drop_count_d    = drop_count_q;
        order_err_d     = order_err_q;
        pc_err_d        = pc_err_q;
        exp_order_d     = exp_order_q;
        have_prev_d     = have_prev_q;
        prev_pc_wdata_d = prev_pc_wdata_q;
        prev_trap_d     = prev_trap_q;

        if (push) begin
            wp_d = wp_q + AW'(1);
        end
        if (pop) begin
            rp_d = rp_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end

        // Continuity checks look at every retirement, including dropped ones.
        if (in_valid) begin
            if (in_order != exp_order_q) begin
                order_err_d = 1'b1;
            end
            exp_order_d = in_order + 64'd1;

            if (have_prev_q && !prev_trap_q && (in_pc_rdata != prev_pc_wdata_q)) begin
                pc_err_d = 1'b1;
            end
            prev_pc_wdata_d = in_pc_wdata;
            prev_trap_d     = in_trap;
            have_prev_d     = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wp_q            <= '0;
            rp_q            <= '0;
            count_q         <= '0;
            overflow_q      <= 1'b0;
            drop_count_q    <= '0;
            order_err_q     <= 1'b0;
            pc_err_q        <= 1'b0;
            exp_order_q     <= '0;
            have_prev_q     <= 1'b0;
            prev_pc_wdata_q <= '0;
            prev_trap_q     <= 1'b0;
        end else begin
            wp_q            <= wp_d;
            rp_q            <= rp_d;
            count_q         <= count_d;
            overflow_q      <= overflow_d;
            drop_count_q    <= drop_count_d;
            order_err_q     <= order_err_d;
            pc_err_q        <= pc_err_d;
            exp_order_q     <= exp_order_d;
            have_prev_q     <= have_prev_d;
            prev_pc_wdata_q <= prev_pc_wdata_d;
            prev_trap_q     <= prev_trap_d;
        end
    end

    // Storage is deliberately not reset; validity is tracked by count_q alone.
    always_ff @(posedge clock) begin
        if (reset && push) begin
            mem_q[wp_q] <= in_entry;
        end
    end

    assign out_valid = (count_q != '0);
    assign head      = out_valid ? mem_q[rp_q] : '0;

    assign out_order     = head.order;
    assign out_insn      = head.insn;
    assign out_trap      = head.trap;
    assign out_pc_rdata  = head.pc_rdata;
    assign out_pc_wdata  = head.pc_wdata;
    assign out_rd_addr   = head.rd_addr;
    assign out_rd_wdata  = head.rd_wdata;
    assign out_mem_addr  = head.mem_addr;
    assign out_mem_wmask = head.mem_wmask;
    assign out_mem_wdata = head.mem_wdata;

    assign count      = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;
    assign order_err  = order_err_q;
    assign pc_err     = pc_err_q;

endmodule

// File: tb/tb_rvfi_trace_buffer.sv
// Self-checking bench for rvfi_trace_buffer: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_rvfi_trace_buffer;

    localparam int DEPTH = 8;
    localparam int CNTW  = $clog2(DEPTH) + 1;

    logic            clock;
    logic            reset;
    logic            in_valid;
    logic [63:0]     in_order;
    logic [31:0]     in_insn;
    logic            in_trap;
    logic [31:0]     in_pc_rdata;
    logic [31:0]     in_pc_wdata;
    logic [4:0]      in_rd_addr;
    logic [31:0]     in_rd_wdata;
    logic [31:0]     in_mem_addr;
    logic [3:0]      in_mem_wmask;
    logic [31:0]     in_mem_wdata;
    logic            out_valid;
    logic            out_ready;
    logic [63:0]     out_order;
    logic [31:0]     out_insn;
    logic            out_trap;
    logic [31:0]     out_pc_rdata;
    logic [31:0]     out_pc_wdata;
    logic [4:0]      out_rd_addr;
    logic [31:0]     out_rd_wdata;
    logic [31:0]     out_mem_addr;
    logic [3:0]      out_mem_wmask;
    logic [31:0]     out_mem_wdata;
    logic [CNTW-1:0] count;
    logic            overflow;
    logic [15:0]     drop_count;
    logic            order_err;
    logic            pc_err;

    typedef struct {
        logic [63:0] order;
        logic [31:0] insn;
        logic        trap;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_wdata;
    } pkt_t;

    rvfi_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_order(in_order), .in_insn(in_insn), .in_trap(in_trap),
        .in_pc_rdata(in_pc_rdata), .in_pc_wdata(in_pc_wdata), .in_rd_addr(in_rd_addr),
        .in_rd_wdata(in_rd_wdata), .in_mem_addr(in_mem_addr), .in_mem_wmask(in_mem_wmask),
        .in_mem_wdata(in_mem_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_order(out_order), .out_insn(out_insn),
        .out_trap(out_trap), .out_pc_rdata(out_pc_rdata), .out_pc_wdata(out_pc_wdata),
        .out_rd_addr(out_rd_addr), .out_rd_wdata(out_rd_wdata), .out_mem_addr(out_mem_addr),
        .out_mem_wmask(out_mem_wmask), .out_mem_wdata(out_mem_wdata),
        .count(count), .overflow(overflow), .drop_count(drop_count),
        .order_err(order_err), .pc_err(pc_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    bit checkEn = 1'b0;

    // Reference model: a FIFO of packets plus the checker's memory of the last retirement.
    pkt_t        modelQ[$];
    bit          mOverflow;
    int          mDropCount;
    bit          mOrderErr;
    bit          mPcErr;
    logic [63:0] mExpOrder;
    bit          mHavePrev;
    logic [31:0] mPrevPcW;
    bit          mPrevTrap;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic pkt_t mkPkt(input logic [63:0] order, input logic [31:0] pcR,
                                   input logic [31:0] pcW, input logic trap);
        pkt_t p;
        p.order     = order;
        p.insn      = $urandom;
        p.trap      = trap;
        p.pc_rdata  = pcR;
        p.pc_wdata  = pcW;
        p.rd_addr   = 5'($urandom);
        p.rd_wdata  = $urandom;
        p.mem_addr  = $urandom;
        p.mem_wmask = 4'($urandom);
        p.mem_wdata = $urandom;
        return p;
    endfunction

    task automatic checkAll();
        pkt_t h;
        logic hv;
        hv = (modelQ.size() != 0);
        h  = hv ? modelQ[0] : mkPkt(64'd0, 32'd0, 32'd0, 1'b0);
        if (!hv) begin
            h.insn = '0; h.rd_addr = '0; h.rd_wdata = '0;
            h.mem_addr = '0; h.mem_wmask = '0; h.mem_wdata = '0;
        end
        checkOutput("out_valid",  64'(out_valid),     64'(hv));
        checkOutput("count",      64'(count),         64'(modelQ.size()));
        checkOutput("out_order",  out_order,          h.order);
        checkOutput("out_insn",   64'(out_insn),      64'(h.insn));
        checkOutput("out_trap",   64'(out_trap),      64'(h.trap));
        checkOutput("out_pc_r",   64'(out_pc_rdata),  64'(h.pc_rdata));
        checkOutput("out_pc_w",   64'(out_pc_wdata),  64'(h.pc_wdata));
        checkOutput("out_rd",     64'(out_rd_addr),   64'(h.rd_addr));
        checkOutput("out_rd_wd",  64'(out_rd_wdata),  64'(h.rd_wdata));
        checkOutput("out_maddr",  64'(out_mem_addr),  64'(h.mem_addr));
        checkOutput("out_wmask",  64'(out_mem_wmask), 64'(h.mem_wmask));
        checkOutput("out_wdata",  64'(out_mem_wdata), 64'(h.mem_wdata));
        checkOutput("overflow",   64'(overflow),      64'(mOverflow));
        checkOutput("drop_count", 64'(drop_count),    64'(mDropCount));
        checkOutput("order_err",  64'(order_err),     64'(mOrderErr));
        checkOutput("pc_err",     64'(pc_err),        64'(mPcErr));
    endtask

    task automatic modelStep(input logic rstN, input logic v, input pkt_t p, input logic rdy);
        bit doPop, doPush;
        if (!rstN) begin
            modelQ.delete();
            mOverflow = 0; mDropCount = 0; mOrderErr = 0; mPcErr = 0;
            mExpOrder = '0; mHavePrev = 0; mPrevPcW = '0; mPrevTrap = 0;
            return;
        end
        doPop  = (modelQ.size() != 0) && rdy;
        doPush = v && ((modelQ.size() < DEPTH) || doPop);
        if (doPop)  void'(modelQ.pop_front());
        if (doPush) modelQ.push_back(p);
        if (v && !doPush) begin
            mOverflow = 1;
            if (mDropCount < 65535) mDropCount++;
        end
        if (v) begin
            if (p.order != mExpOrder) mOrderErr = 1;
            mExpOrder = p.order + 64'd1;
            if (mHavePrev && !mPrevTrap && p.pc_rdata != mPrevPcW) mPcErr = 1;
            mPrevPcW  = p.pc_wdata;
            mPrevTrap = p.trap;
            mHavePrev = 1;
        end
    endtask

    // One cycle: check at the falling edge, drive, then advance the model at the rising edge.
    task automatic applyStimulus(input logic rstN, input logic v, input pkt_t p, input logic rdy);
        @(negedge clock);
        if (checkEn) checkAll();
        reset        = rstN;
        in_valid     = v;
        in_order     = p.order;
        in_insn      = p.insn;
        in_trap      = p.trap;
        in_pc_rdata  = p.pc_rdata;
        in_pc_wdata  = p.pc_wdata;
        in_rd_addr   = p.rd_addr;
        in_rd_wdata  = p.rd_wdata;
        in_mem_addr  = p.mem_addr;
        in_mem_wmask = p.mem_wmask;
        in_mem_wdata = p.mem_wdata;
        out_ready    = rdy;
        @(posedge clock);
        modelStep(rstN, v, p, rdy);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, mkPkt(64'd0, 32'd0, 32'd0, 1'b0), 1'b0);
    endtask

    task automatic idle(input logic rdy);
        applyStimulus(1'b1, 1'b0, mkPkt(64'd0, 32'd0, 32'd0, 1'b0), rdy);
    endtask

    initial begin
        pkt_t p;
        logic [63:0] nextOrder;
        logic [31:0] nextPc;

        doReset();
        checkEn = 1'b1;
        doReset();

        // Three chained retirements straight through
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, mkPkt(64'(i), 32'(4 * i), 32'(4 * i + 4), 1'b0), 1'b1);
            checkOutput("t1_head_order", out_order, 64'(i));
            checkOutput("t1_count", 64'(count), 64'd1);
        end
        idle(1'b1);
        checkOutput("t1_empty", 64'(out_valid), 64'd0);

        // Overflow with the sink stalled, then drain
        doReset();
        for (int i = 0; i < DEPTH + 2; i++)
            applyStimulus(1'b1, 1'b1, mkPkt(64'(i), 32'(4 * i), 32'(4 * i + 4), 1'b0), 1'b0);
        checkOutput("t2_count", 64'(count), 64'(DEPTH));
        checkOutput("t2_overflow", 64'(overflow), 64'd1);
        checkOutput("t2_drops", 64'(drop_count), 64'd2);
        checkOutput("t2_order_err", 64'(order_err), 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("t2_drain_order", out_order, 64'(i));
            idle(1'b1);
        end
        checkOutput("t2_drained", 64'(out_valid), 64'd0);

        // Simultaneous push and pop on a full FIFO
        doReset();
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1'b1, 1'b1, mkPkt(64'(i), 32'(4 * i), 32'(4 * i + 4), 1'b0), 1'b0);
        applyStimulus(1'b1, 1'b1, mkPkt(64'(DEPTH), 32'(4 * DEPTH), 32'(4 * DEPTH + 4), 1'b0), 1'b1);
        checkOutput("t3_count", 64'(count), 64'(DEPTH));
        checkOutput("t3_no_drop", 64'(overflow), 64'd0);
        for (int i = 1; i < DEPTH; i++) idle(1'b1);
        checkOutput("t3_last", out_order, 64'(DEPTH));
        idle(1'b1);
        checkOutput("t3_empty", 64'(count), 64'd0);

        // Order discontinuity 0,1,3 then 4
        doReset();
        applyStimulus(1'b1, 1'b1, mkPkt(64'd0, 32'h0, 32'h4, 1'b0), 1'b1);
        applyStimulus(1'b1, 1'b1, mkPkt(64'd1, 32'h4, 32'h8, 1'b0), 1'b1);
        checkOutput("t4_before", 64'(order_err), 64'd0);
        applyStimulus(1'b1, 1'b1, mkPkt(64'd3, 32'h8, 32'hC, 1'b0), 1'b1);
        checkOutput("t4_set", 64'(order_err), 64'd1);
        applyStimulus(1'b1, 1'b1, mkPkt(64'd4, 32'hC, 32'h10, 1'b0), 1'b1);
        checkOutput("t4_sticky", 64'(order_err), 64'd1);

        // PC chain break, then the same break following a trap
        doReset();
        applyStimulus(1'b1, 1'b1, mkPkt(64'd0, 32'h0, 32'h100, 1'b0), 1'b1);
        applyStimulus(1'b1, 1'b1, mkPkt(64'd1, 32'h200, 32'h204, 1'b0), 1'b1);
        checkOutput("t5_pc_err", 64'(pc_err), 64'd1);
        doReset();
        applyStimulus(1'b1, 1'b1, mkPkt(64'd0, 32'h0, 32'h100, 1'b1), 1'b1);
        applyStimulus(1'b1, 1'b1, mkPkt(64'd1, 32'h200, 32'h204, 1'b0), 1'b1);
        checkOutput("t5_trap_ok", 64'(pc_err), 64'd0);

        // Reset with entries queued and flags set
        doReset();
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 1'b1, mkPkt(64'(i < 3 ? i : i + 2), 32'(4 * i), 32'(4 * i + 4), 1'b0), 1'b0);
        checkOutput("t6_count5", 64'(count), 64'd5);
        checkOutput("t6_err_set", 64'(order_err), 64'd1);
        applyStimulus(1'b0, 1'b1, mkPkt(64'd9, 32'h0, 32'h4, 1'b0), 1'b0);
        checkOutput("t6_count0", 64'(count), 64'd0);
        checkOutput("t6_out_order", out_order, 64'd0);
        checkOutput("t6_err_clr", 64'(order_err), 64'd0);

        // Random traffic with occasional faults, traps and resets
        doReset();
        nextOrder = '0;
        nextPc    = 32'h1000;
        for (int c = 0; c < 3000; c++) begin
            logic v, rdy, rstN;
            rstN = ($urandom_range(0, 499) != 0);
            v    = ($urandom_range(0, 3) != 0);
            rdy  = (c % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            p    = mkPkt(nextOrder, nextPc, nextPc + 32'd4, ($urandom_range(0, 15) == 0));
            if ($urandom_range(0, 63) == 0) p.order    = p.order + 64'd2;
            if ($urandom_range(0, 63) == 0) p.pc_rdata = p.pc_rdata ^ 32'h40;
            if ($urandom_range(0, 7) == 0)  p.pc_wdata = $urandom;
            applyStimulus(rstN, v, p, rdy);
            if (!rstN) begin
                nextOrder = '0;
            end else if (v) begin
                nextOrder = p.order + 64'd1;
                nextPc    = p.pc_wdata;
            end
        end
        idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
